// File: rtl/gpu_texel_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpu_texel_fetch : two-stage texel fetch / wall-ceiling-floor colour pipeline
// Revision 1.0
// ---------------------------------------------------------------------------
module gpu_texel_fetch #(
  parameter int          TEXTURE_SIZE = 64,
  parameter int          TEX_COUNT    = 4,
  parameter int          SCREEN_HALF  = 240,
  parameter logic [7:0]  CEIL_COLOR   = 8'h49,
  parameter logic [7:0]  FLOOR_COLOR  = 8'h24,
  localparam int         AW           = $clog2(TEXTURE_SIZE),
  localparam int         TW           = $clog2(TEX_COUNT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inside_wall,
  input  logic [AW:0]       uv_y,
  input  logic [AW-1:0]     uv_x,
  input  logic [TW-1:0]     tex_id,
  input  logic [9:0]        screen_x,
  input  logic [9:0]        screen_y,
  output logic              tex_rd_en,
  output logic [TW+2*AW-1:0] tex_addr,
  input  logic [7:0]        tex_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_color,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y
);

  localparam logic [AW:0] C_TEX_SIZE = (AW+1)'(TEXTURE_SIZE);
  localparam logic [9:0]  C_HORIZON  = 10'(SCREEN_HALF);

  logic          s1_valid_q, s1_valid_d;
  logic          s1_fresh_q, s1_fresh_d;
  logic          s1_wall_q, s1_wall_d;
  logic          s1_region_q, s1_region_d;
  logic [9:0]    s1_x_q, s1_x_d;
  logic [9:0]    s1_y_q, s1_y_d;
  logic [7:0]    s1_data_q, s1_data_d;
  logic          s2_valid_q, s2_valid_d;
  logic [7:0]    s2_color_q, s2_color_d;
  logic [9:0]    s2_x_q, s2_x_d;
  logic [9:0]    s2_y_q, s2_y_d;

  logic          s2_free_w;
  logic          accept_w;
  logic          s1_move_w;
  logic [AW-1:0] row_w;
  logic [7:0]    s1_color_w;

  assign s2_free_w = !s2_valid_q || out_ready;
  // Gating with reset keeps the request side closed while reset is held.
  assign in_ready  = reset && !flush && (!s1_valid_q || s2_free_w);
  assign accept_w  = in_valid && in_ready;
  assign s1_move_w = s1_valid_q && s2_free_w;

  assign row_w     = (uv_y >= C_TEX_SIZE) ? {AW{1'b1}} : uv_y[AW-1:0];
  assign tex_addr  = {tex_id, row_w, uv_x};
  assign tex_rd_en = accept_w && inside_wall;

  // ROM data is only on the bus the cycle after the read; later use the copy.
  assign s1_color_w = s1_wall_q ? (s1_fresh_q ? tex_data : s1_data_q)
                                : (s1_region_q ? CEIL_COLOR : FLOOR_COLOR);

  assign out_valid = s2_valid_q;
  assign out_color = s2_color_q;
  assign out_x     = s2_x_q;
  assign out_y     = s2_y_q;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_fresh_d  = accept_w;
    s1_wall_d   = s1_wall_q;
    s1_region_d = s1_region_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_data_d   = s1_data_q;
    s2_valid_d  = s2_valid_q;
    s2_color_d  = s2_color_q;
    s2_x_d      = s2_x_q;
    s2_y_d      = s2_y_q;

    if (s1_fresh_q) s1_data_d = tex_data;

    if (accept_w) begin
      s1_wall_d   = inside_wall;
      s1_region_d = (screen_y < C_HORIZON);
      s1_x_d      = screen_x;
      s1_y_d      = screen_y;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s1_fresh_d = 1'b0;
    end else if (accept_w) begin
      s1_valid_d = 1'b1;
    end else if (s1_move_w) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move_w) begin
      s2_color_d = s1_color_w;
      s2_x_d     = s1_x_q;
      s2_y_d     = s1_y_q;
    end

    if (flush) begin
      s2_valid_d = 1'b0;
    end else if (s1_move_w) begin
      s2_valid_d = 1'b1;
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_fresh_q  <= 1'b0;
      s1_wall_q   <= 1'b0;
      s1_region_q <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_data_q   <= '0;
      s2_valid_q  <= 1'b0;
      s2_color_q  <= '0;
      s2_x_q      <= '0;
      s2_y_q      <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_fresh_q  <= s1_fresh_d;
      s1_wall_q   <= s1_wall_d;
      s1_region_q <= s1_region_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_data_q   <= s1_data_d;
      s2_valid_q  <= s2_valid_d;
      s2_color_q  <= s2_color_d;
      s2_x_q      <= s2_x_d;
      s2_y_q      <= s2_y_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/gpu_texel_fetch.md
GPU_TEXEL_FETCH -- requirements
Module: gpu_texel_fetch

Interface
REQ-001 SHALL have parameter TEXTURE_SIZE, default 64, texture edge in texels (power of two); AW = log2(TEXTURE_SIZE).
REQ-002 SHALL have parameter TEX_COUNT, default 4, number of textures (power of two); TW = log2(TEX_COUNT).
REQ-003 SHALL have parameter SCREEN_HALF, default 240, integer row of the horizon.
REQ-004 SHALL have parameters CEIL_COLOR, default 8'h49, and FLOOR_COLOR, default 8'h24, the 8-bit colours used outside walls.
REQ-005 SHALL have ports:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low
  flush  in  1  synchronous pipeline clear (frame start)
  in_valid  in  1  pixel request valid
  in_ready  out  1  request accepted when in_valid && in_ready
  inside_wall  in  1  pixel lies on a wall slice
  uv_y  in  AW+1  texture row from the lookup stage, range 0..TEXTURE_SIZE
  uv_x  in  AW  texture column of the current screen column
  tex_id  in  TW  texture select of the current column
  screen_x  in  10  pixel column tag
  screen_y  in  10  pixel row tag
  tex_rd_en  out  1  texture ROM read strobe
  tex_addr  out  TW+2*AW  ROM address {tex_id, row, uv_x}
  tex_data  in  8  ROM read data, valid exactly one cycle after tex_rd_en
  out_valid  out  1  pixel result valid
  out_ready  in  1  consumer accepts when out_valid && out_ready
  out_color  out  8  final pixel colour
  out_x  out  10  screen_x tag of the result
  out_y  out  10  screen_y tag of the result

Function
REQ-006 SHALL implement two registered stages, S1 (fetch) and S2 (output), each with its own valid bit; throughput one pixel per cycle.
REQ-007 SHALL define s2_free = !s2_valid || out_ready and in_ready = !flush && (!s1_valid || s2_free).
REQ-008 SHALL, in the accept cycle, drive tex_rd_en = 1 iff inside_wall; tex_addr combinationally from current inputs; tex_rd_en = 0 in all other cycles.
REQ-009 SHALL clamp the row: row = TEXTURE_SIZE-1 when uv_y >= TEXTURE_SIZE, else uv_y[AW-1:0].
REQ-010 SHALL, on accept, load S1 with screen_x, screen_y, inside_wall, and region = (screen_y < SCREEN_HALF), and set an s1_fresh flag.
REQ-011 SHALL, in the cycle after accept (s1_fresh = 1), latch tex_data into an S1 data register; s1_fresh clears the following cycle even if S1 stalls.
REQ-012 SHALL compute S1 colour = inside_wall ? (s1_fresh ? tex_data : latched data) : (region ? CEIL_COLOR : FLOOR_COLOR).
REQ-013 SHALL move S1 into S2 when s1_valid && s2_free; S2 holds colour/x/y stable while out_valid && !out_ready.
REQ-014 SHALL clear s2_valid when S2 drains (out_ready) and S1 does not refill it.
REQ-015 SHALL allow simultaneous S1->S2 transfer and new accept into S1 in one cycle.
REQ-016 SHALL give latency of 2 cycles: accept at edge N, out_valid at edge N+2 with no backpressure.
REQ-017 SHALL, on flush, clear s1_valid, s2_valid and s1_fresh at the next edge; flush blocks accept that cycle; no tex_rd_en while flush = 1.
REQ-018 SHALL never drop, duplicate or reorder pixels; output order equals accept order.

Reset
REQ-019 SHALL, while reset = 0, asynchronously force s1_valid = 0, s2_valid = 0, s1_fresh = 0, out_color = 0, out_x = 0, out_y = 0; tex_rd_en = 0, in_ready = 0.
REQ-020 SHALL resume accepting on the first rising clk edge after reset deasserts; reset mid-stream discards all in-flight pixels.

Verification
REQ-021 Single wall pixel: tex_id=1, uv_y=5, uv_x=9, x=100, y=200, inside_wall=1, ROM returns 8'hA5 -> tex_addr=14'h1149, one tex_rd_en pulse, out_color=A5, out_x=100, out_y=200 two cycles later.
REQ-022 Non-wall pixels at y=10 and y=400 -> no tex_rd_en; out_color=49 then 24.
REQ-023 Row clamp: uv_y=64, uv_x=0, tex_id=0 -> tex_addr row field = 63 (addr 14'h0FC0).
REQ-024 Backpressure: stream 8 wall pixels, out_ready low for 5 cycles after first result -> in_ready falls once S1 and S2 are full; all 8 colours emerge in order with correct latched ROM data.
REQ-025 Flush/reset mid-stream: flush with S1 and S2 full -> out_valid=0 next cycle, no stale output; repeat with reset asserted asynchronously between edges -> outputs zero immediately.
